// File: rtl/sobel5_edge.sv
// sobel5_edge: 4-stage 5x5 Sobel magnitude, scale/saturate, threshold, sideband delay.
// Define SOBEL_STATS_EN to add the per-frame edge counter and frame_edges port.
module sobel5_edge #(
    parameter int SHIFT  = 6,
    parameter int BORDER = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [10:0]  hcount_in,
    input  logic [9:0]   vcount_in,
    input  logic         hsync_in,
    input  logic         vsync_in,
    input  logic         blank_in,
    input  logic [199:0] matrix,
    input  logic [7:0]   threshold,
    output logic [7:0]   pixel_out,
    output logic         edge_out,
    output logic [10:0]  hcount_out,
    output logic [9:0]   vcount_out,
    output logic         hsync_out,
    output logic         vsync_out,
    output logic         blank_out
`ifdef SOBEL_STATS_EN
    ,
    output logic [19:0]  frame_edges
`endif
);

    localparam logic [10:0] H_BORDER = 11'(BORDER);
    localparam logic [9:0]  V_BORDER = 10'(BORDER);

    // Weights -1 -2 0 +2 +1 applied to taps 4..0 of one row or column
    function automatic logic signed [11:0] f_wsum(
        input logic [7:0] a4,
        input logic [7:0] a3,
        input logic [7:0] a1,
        input logic [7:0] a0
    );
        f_wsum = $signed({3'b0, a1, 1'b0}) - $signed({3'b0, a3, 1'b0})
               + $signed({4'b0, a0}) - $signed({4'b0, a4});
    endfunction

    // Smoothing multipliers 1 4 6 4 1
    function automatic logic signed [15:0] f_mix(
        input logic signed [11:0] e4,
        input logic signed [11:0] e3,
        input logic signed [11:0] e2,
        input logic signed [11:0] e1,
        input logic signed [11:0] e0
    );
        logic signed [15:0] x4, x3, x2, x1, x0;
        x4 = $signed({{4{e4[11]}}, e4});
        x3 = $signed({{4{e3[11]}}, e3});
        x2 = $signed({{4{e2[11]}}, e2});
        x1 = $signed({{4{e1[11]}}, e1});
        x0 = $signed({{4{e0[11]}}, e0});
        f_mix = x4 + x0 + ((x3 + x1) <<< 2) + (x2 <<< 2) + (x2 <<< 1);
    endfunction

    logic [7:0]         w_px [5][5];
    logic signed [11:0] w_rx [5];
    logic signed [11:0] w_cy [5];
    logic               w_keep;

    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                w_px[r][c] = matrix[8*(5*r+c) +: 8];
            end
        end
        for (int i = 0; i < 5; i++) begin
            w_rx[i] = f_wsum(w_px[i][4], w_px[i][3], w_px[i][1], w_px[i][0]);
            w_cy[i] = f_wsum(w_px[4][i], w_px[3][i], w_px[1][i], w_px[0][i]);
        end
        w_keep = ~(blank_in | (hcount_in < H_BORDER) | (vcount_in < V_BORDER));
    end

    logic signed [11:0] r_rx [5];
    logic signed [11:0] r_cy [5];
    logic signed [15:0] r_gx, r_gy;
    logic [14:0]        r_mag;
    logic [7:0]         r_thr [3];
    logic               r_keep [3];
    logic [23:0]        r_sb [4];

    logic [14:0] w_ax, w_ay, w_s;
    logic [7:0]  w_pix;

    assign w_ax  = r_gx[15] ? 15'(-r_gx) : 15'(r_gx);
    assign w_ay  = r_gy[15] ? 15'(-r_gy) : 15'(r_gy);
    assign w_s   = r_mag >> SHIFT;
    assign w_pix = (w_s > 15'd255) ? 8'hFF : w_s[7:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) begin
                r_rx[i] <= '0;
                r_cy[i] <= '0;
            end
            r_gx  <= '0;
            r_gy  <= '0;
            r_mag <= '0;
        end else begin
            r_rx  <= w_rx;
            r_cy  <= w_cy;
            r_gx  <= f_mix(r_rx[4], r_rx[3], r_rx[2], r_rx[1], r_rx[0]);
            r_gy  <= f_mix(r_cy[4], r_cy[3], r_cy[2], r_cy[1], r_cy[0]);
            r_mag <= w_ax + w_ay;
        end
    end

    // Keep flag resets to 0 so the pipeline fill emits clean zeros
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                r_thr[i]  <= '0;
                r_keep[i] <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                r_sb[i] <= '0;
            end
            pixel_out <= '0;
            edge_out  <= 1'b0;
        end else begin
            r_thr[0]  <= threshold;
            r_keep[0] <= w_keep;
            r_sb[0]   <= {hcount_in, vcount_in, hsync_in, vsync_in, blank_in};
            for (int i = 1; i < 3; i++) begin
                r_thr[i]  <= r_thr[i-1];
                r_keep[i] <= r_keep[i-1];
            end
            for (int i = 1; i < 4; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
            pixel_out <= r_keep[2] ? w_pix : 8'd0;
            edge_out  <= r_keep[2] && (w_pix >= r_thr[2]);
        end
    end

    assign {hcount_out, vcount_out, hsync_out, vsync_out, blank_out} = r_sb[3];

`ifdef SOBEL_STATS_EN
    logic [19:0] r_cnt;
    logic        r_vs_d;
    logic        w_hit;

    assign w_hit = edge_out & ~blank_out;

    // A hit on the vsync rising cycle belongs to the new frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_vs_d      <= 1'b0;
            frame_edges <= '0;
        end else begin
            r_vs_d <= vsync_out;
            if (vsync_out && !r_vs_d) begin
                frame_edges <= r_cnt;
                r_cnt       <= {19'b0, w_hit};
            end else if (w_hit && (r_cnt != 20'hFFFFF)) begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sobel5_edge.sv
// tb_sobel5_edge: directed and random checks of sobel5_edge against a kernel-table model.
// Two instances: SHIFT=6 (default) and SHIFT=5 fed the same stream.
module tb_sobel5_edge;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [10:0]  hcount_in;
    logic [9:0]   vcount_in;
    logic         hsync_in, vsync_in, blank_in;
    logic [199:0] matrix;
    logic [7:0]   threshold;

    logic [7:0]  pix_a, pix_b;
    logic        edg_a, edg_b;
    logic [10:0] hc_a, hc_b;
    logic [9:0]  vc_a, vc_b;
    logic        hs_a, hs_b, vs_a, vs_b, bl_a, bl_b;
`ifdef SOBEL_STATS_EN
    logic [19:0] fe_a, fe_b;
`endif

    always #5 clock = ~clock;

    sobel5_edge u_a (
        .clock(clock), .reset_n(reset_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .matrix(matrix), .threshold(threshold),
        .pixel_out(pix_a), .edge_out(edg_a),
        .hcount_out(hc_a), .vcount_out(vc_a),
        .hsync_out(hs_a), .vsync_out(vs_a), .blank_out(bl_a)
`ifdef SOBEL_STATS_EN
        , .frame_edges(fe_a)
`endif
    );

    sobel5_edge #(.SHIFT(5), .BORDER(4)) u_b (
        .clock(clock), .reset_n(reset_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .matrix(matrix), .threshold(threshold),
        .pixel_out(pix_b), .edge_out(edg_b),
        .hcount_out(hc_b), .vcount_out(vc_b),
        .hsync_out(hs_b), .vsync_out(vs_b), .blank_out(bl_b)
`ifdef SOBEL_STATS_EN
        , .frame_edges(fe_b)
`endif
    );

    typedef struct {
        logic [7:0]  pix6;
        logic [7:0]  pix5;
        logic        edg6;
        logic        edg5;
        logic [23:0] sb;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_step = 0;

    function automatic int gmag(input logic [199:0] m);
        int w[5] = '{1, 2, 0, -2, -1};
        int s[5] = '{1, 4, 6, 4, 1};
        int gx = 0;
        int gy = 0;
        int p;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                p = int'(m[8*(5*r+c) +: 8]);
                gx += s[r] * w[c] * p;
                gy += w[r] * s[c] * p;
            end
        end
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    function automatic logic [7:0] scale(input int mag, input int sh);
        int v;
        v = mag >> sh;
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    function automatic logic [199:0] mk_uni(input logic [7:0] v);
        logic [199:0] m;
        for (int k = 0; k < 25; k++) m[8*k +: 8] = v;
        return m;
    endfunction

    function automatic logic [199:0] mk_vstep();
        logic [199:0] m;
        for (int k = 0; k < 25; k++) m[8*k +: 8] = ((k % 5) < 2) ? 8'd255 : 8'd0;
        return m;
    endfunction

    function automatic logic [199:0] mk_hstep();
        logic [199:0] m;
        for (int k = 0; k < 25; k++) m[8*k +: 8] = ((k / 5) < 2) ? 8'd255 : 8'd0;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pix"}, {24'd0, pix_a}, 32'd0);
        chk({tag, "_edge"}, {31'd0, edg_a}, 32'd0);
        chk({tag, "_sb"}, {8'd0, hc_a, vc_a, hs_a, vs_a, bl_a}, 32'd0);
        chk({tag, "_pix5"}, {24'd0, pix_b}, 32'd0);
        chk({tag, "_sb5"}, {8'd0, hc_b, vc_b, hs_b, vs_b, bl_b}, 32'd0);
    endtask

    task automatic step(
        input string        tag,
        input logic [199:0] m,
        input logic [10:0]  hc,
        input logic [9:0]   vc,
        input logic         hs,
        input logic         vs,
        input logic         bl,
        input logic [7:0]   thr
    );
        exp_t  e;
        int    mg;
        logic  msk;
        string t;
        matrix    = m;
        hcount_in = hc;
        vcount_in = vc;
        hsync_in  = hs;
        vsync_in  = vs;
        blank_in  = bl;
        threshold = thr;
        mg  = gmag(m);
        msk = bl || (hc < 11'd4) || (vc < 10'd4);
        e.pix6 = msk ? 8'd0 : scale(mg, 6);
        e.pix5 = msk ? 8'd0 : scale(mg, 5);
        e.edg6 = !msk && (e.pix6 >= thr);
        e.edg5 = !msk && (e.pix5 >= thr);
        e.sb   = {hc, vc, hs, vs, bl};
        q.push_back(e);
        n_step++;
        @(posedge clock);
        #1;
        if (q.size() == 4) begin
            e = q.pop_front();
            t = $sformatf("%s@%0d", tag, n_step);
            chk({t, "_pix"}, {24'd0, pix_a}, {24'd0, e.pix6});
            chk({t, "_edge"}, {31'd0, edg_a}, {31'd0, e.edg6});
            chk({t, "_sb"}, {8'd0, hc_a, vc_a, hs_a, vs_a, bl_a}, {8'd0, e.sb});
            chk({t, "_pix5"}, {24'd0, pix_b}, {24'd0, e.pix5});
            chk({t, "_edge5"}, {31'd0, edg_b}, {31'd0, e.edg5});
            chk({t, "_sb5"}, {8'd0, hc_b, vc_b, hs_b, vs_b, bl_b}, {8'd0, e.sb});
        end
    endtask

    initial begin
        logic [199:0] rm;
        logic [10:0]  rhc;
        logic [9:0]   rvc;

        reset_n   = 1'b0;
        matrix    = '0;
        hcount_in = '0;
        vcount_in = '0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        blank_in  = 1'b0;
        threshold = '0;
        repeat (2) @(posedge clock);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        step("uni",    mk_uni(8'd100), 11'd100, 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
        step("vstep",  mk_vstep(),     11'd100, 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
        step("hstep",  mk_hstep(),     11'd101, 10'd100, 1'b1, 1'b0, 1'b0, 8'd128);
        step("hst192", mk_hstep(),     11'd102, 10'd100, 1'b0, 1'b1, 1'b0, 8'd192);
        step("hc2",    mk_vstep(),     11'd2,   10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
        step("blank",  mk_vstep(),     11'd104, 10'd100, 1'b0, 1'b0, 1'b1, 8'd128);
        step("nbr",    mk_vstep(),     11'd105, 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
        step("vc3",    mk_vstep(),     11'd106, 10'd3,   1'b0, 1'b0, 1'b0, 8'd128);
        step("bord4",  mk_vstep(),     11'd4,   10'd4,   1'b0, 1'b0, 1'b0, 8'd128);
        step("hcmax",  mk_hstep(),     11'd2047, 10'd50, 1'b0, 1'b0, 1'b0, 8'd0);
        step("hcwrap", mk_hstep(),     11'd0,   10'd50,  1'b0, 1'b0, 1'b0, 8'd0);
        step("thr0",   mk_uni(8'd7),   11'd300, 10'd300, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) step("flush", mk_uni(8'd0), 11'd200, 10'd200, 1'b0, 1'b0, 1'b0, 8'd1);

        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 25; k++) rm[8*k +: 8] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rm = $urandom_range(0, 1) ? mk_vstep() : mk_hstep();
            rhc = $urandom_range(0, 1) ? 11'($urandom_range(0, 8)) : 11'($urandom_range(0, 2047));
            rvc = $urandom_range(0, 1) ? 10'($urandom_range(0, 8)) : 10'($urandom_range(0, 1023));
            step("rand", rm, rhc, rvc, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        repeat (6) step("prerst", mk_vstep(), 11'd100, 10'd100, 1'b1, 1'b1, 1'b0, 8'd100);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        q.delete();
        @(posedge clock);
        #1;
        chk_zero("held_rst");
        reset_n = 1'b1;
        repeat (6) step("postrst", mk_vstep(), 11'd100, 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);

`ifdef SOBEL_STATS_EN
        repeat (5) step("st_idle", mk_uni(8'd9), 11'd100, 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
        step("st_vs0", mk_uni(8'd9), 11'd100, 10'd100, 1'b0, 1'b1, 1'b0, 8'd128);
        for (int i = 0; i < 40; i++) begin
            if (i == 10 || i == 20 || i == 30)
                step("st_flat", mk_uni(8'd50), 11'd100, 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
            else
                step("st_edge", mk_vstep(), 11'(100 + i), 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
        end
        step("st_vs1", mk_uni(8'd9), 11'd100, 10'd100, 1'b0, 1'b1, 1'b0, 8'd128);
        repeat (4) step("st_tail", mk_uni(8'd9), 11'd100, 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
        chk("frame_edges37", {12'd0, fe_a}, 32'd37);
        chk("frame_edges37_b", {12'd0, fe_b}, 32'd37);
        repeat (10) step("st_none", mk_uni(8'd9), 11'd100, 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
        step("st_vs2", mk_uni(8'd9), 11'd100, 10'd100, 1'b0, 1'b1, 1'b0, 8'd128);
        repeat (4) step("st_tail2", mk_uni(8'd9), 11'd100, 10'd100, 1'b0, 1'b0, 1'b0, 8'd128);
        chk("frame_edges0", {12'd0, fe_a}, 32'd0);
        chk("frame_edges0_b", {12'd0, fe_b}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
